// File: rtl/garage_ctrl_multi.sv
// Multi-door garage controller: one independent FSM per door, each with mid-travel
// stop/resume, obstruction auto-reverse, a run watchdog and an optional auto-close.
module garage_door_ch #(
   parameter int MOVE_TIMEOUT = 1000,
   parameter int AUTO_CLOSE   = 0,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic activate,
   input  logic up_max,
   input  logic dn_max,
   input  logic obstruct,
   input  logic clr_fault,
   output logic up_m,
   output logic dn_m,
   output logic fault,
   output logic run_nxt
);
   typedef enum logic [1:0] {IDLE, MV_UP, MV_DN, FAULT} state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] AC_LAST = CNT_W'((AUTO_CLOSE > 0) ? AUTO_CLOSE - 1 : 0);

   state_t           state, nxt;
   logic [CNT_W-1:0] tmr, tmr_nxt;
   logic             act_q, act_rise;
   logic             last_up, last_up_nxt;

   assign act_rise = activate & ~act_q;

   always_comb begin
      nxt     = state;
      tmr_nxt = tmr;
      case (state)
         IDLE: begin
            tmr_nxt = '0;
            if (act_rise) begin
               if (up_max && dn_max)       nxt = FAULT;
               else if (dn_max)            nxt = MV_UP;
               else if (up_max || last_up) begin
                  if (!obstruct)           nxt = MV_DN;
               end
               else                        nxt = MV_UP;
            end
            else if (AUTO_CLOSE > 0 && up_max && !dn_max && !obstruct) begin
               if (tmr == AC_LAST) nxt = MV_DN;
               else                tmr_nxt = tmr + 1'b1;
            end
         end
         MV_UP: begin
            if (up_max)              nxt = IDLE;
            else if (act_rise)       nxt = IDLE;
            else if (tmr == TO_LAST) nxt = FAULT;
            else                     tmr_nxt = tmr + 1'b1;
         end
         MV_DN: begin
            if (dn_max)              nxt = IDLE;
            else if (obstruct)       nxt = MV_UP;
            else if (act_rise)       nxt = IDLE;
            else if (tmr == TO_LAST) nxt = FAULT;
            else                     tmr_nxt = tmr + 1'b1;
         end
         default: begin
            if (clr_fault) nxt = IDLE;
         end
      endcase
      // Any state change (including auto-reverse) restarts the timer.
      if (nxt != state) tmr_nxt = '0;
      last_up_nxt = last_up;
      if (nxt == MV_UP)      last_up_nxt = 1'b1;
      else if (nxt == MV_DN) last_up_nxt = 1'b0;
   end

   assign run_nxt = (nxt == MV_UP) || (nxt == MV_DN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tmr     <= '0;
         act_q   <= 1'b0;
         last_up <= 1'b0;
         up_m    <= 1'b0;
         dn_m    <= 1'b0;
         fault   <= 1'b0;
      end
      else begin
         state   <= nxt;
         tmr     <= tmr_nxt;
         act_q   <= activate;
         last_up <= last_up_nxt;
         up_m    <= (nxt == MV_UP);
         dn_m    <= (nxt == MV_DN);
         fault   <= (nxt == FAULT);
      end
   end
endmodule

module garage_ctrl_multi #(
   parameter int N_DOORS      = 2,
   parameter int MOVE_TIMEOUT = 1000,
   parameter int AUTO_CLOSE   = 0,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_DOORS-1:0] activate,
   input  logic [N_DOORS-1:0] up_max,
   input  logic [N_DOORS-1:0] dn_max,
   input  logic [N_DOORS-1:0] obstruct,
   input  logic [N_DOORS-1:0] clr_fault,
   output logic [N_DOORS-1:0] up_m,
   output logic [N_DOORS-1:0] dn_m,
   output logic [N_DOORS-1:0] fault,
   output logic               busy
);
   logic [N_DOORS-1:0] run_nxt;

   for (genvar d = 0; d < N_DOORS; d++) begin : g_door
      garage_door_ch #(
         .MOVE_TIMEOUT(MOVE_TIMEOUT),
         .AUTO_CLOSE  (AUTO_CLOSE),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .activate (activate[d]),
         .up_max   (up_max[d]),
         .dn_max   (dn_max[d]),
         .obstruct (obstruct[d]),
         .clr_fault(clr_fault[d]),
         .up_m     (up_m[d]),
         .dn_m     (dn_m[d]),
         .fault    (fault[d]),
         .run_nxt  (run_nxt[d])
      );
   end

   // Built from next-state enables so busy lines up with the registered motors.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= 1'b0;
      else     busy <= |run_nxt;
   end
endmodule

// File: tb/tb_garage_ctrl_multi.sv
// Directed bench for garage_ctrl_multi (2 doors, timeout 8, auto-close 5).
module tb_garage_ctrl_multi;
   logic       clk, rst;
   logic [1:0] activate, up_max, dn_max, obstruct, clr_fault;
   logic [1:0] up_m, dn_m, fault;
   logic       busy;
   int         checks = 0;
   int         errors = 0;

   garage_ctrl_multi #(.N_DOORS(2), .MOVE_TIMEOUT(8), .AUTO_CLOSE(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .activate(activate), .up_max(up_max), .dn_max(dn_max),
      .obstruct(obstruct), .clr_fault(clr_fault), .up_m(up_m), .dn_m(dn_m),
      .fault(fault), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] act, up, dn, obs, clr;
      logic [1:0] e_up, e_dn, e_flt;
      logic       e_busy;
      string      nm;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [1:0] eu, input logic [1:0] ed,
                          input logic [1:0] ef);
      chk({nm, ".up_m"},  up_m,  eu);
      chk({nm, ".dn_m"},  dn_m,  ed);
      chk({nm, ".fault"}, fault, ef);
      chk({nm, ".busy"},  {1'b0, busy}, {1'b0, |(eu | ed)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks_chk(input int n, input string nm, input logic [1:0] eu,
                            input logic [1:0] ed, input logic [1:0] ef);
      for (int i = 0; i < n; i++) begin
         tick();
         chk_out(nm, eu, ed, ef);
      end
   endtask

   initial begin
      tbl[0]  = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b1, "both_start"};
      tbl[1]  = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 1'b1, "both_run"};
      tbl[2]  = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, "d0_open"};
      tbl[3]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "d1_closed"};
      tbl[4]  = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, "both_lim_flt"};
      tbl[5]  = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, "flt_hold"};
      tbl[6]  = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, "flt_act_ign"};
      tbl[7]  = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, "clr_other"};
      tbl[8]  = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, "clr_flt"};
      tbl[9]  = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "idle_closed"};
      tbl[10] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "obs_blocks_dn"};
      tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, "quiet"};

      rst = 1'b1;
      {activate, up_max, dn_max, obstruct, clr_fault} = '0;
      #12;
      chk_out("reset", 2'b00, 2'b00, 2'b00);
      rst = 1'b0;

      // 1: async reset mid-travel, then a normal open run
      dn_max = 2'b01; activate = 2'b01;
      tick(); chk_out("s1_up", 2'b01, 2'b00, 2'b00);
      dn_max = 2'b00; activate = 2'b00;
      tick(); chk_out("s1_run", 2'b01, 2'b00, 2'b00);
      #2 rst = 1'b1;
      #1 chk_out("s1_async_rst", 2'b00, 2'b00, 2'b00);
      #1 rst = 1'b0;
      dn_max = 2'b01; activate = 2'b01;
      tick(); chk_out("s1_up2", 2'b01, 2'b00, 2'b00);
      dn_max = 2'b00; activate = 2'b00;
      ticks_chk(3, "s1_travel", 2'b01, 2'b00, 2'b00);
      up_max = 2'b01;
      tick(); chk_out("s1_open", 2'b00, 2'b00, 2'b00);

      // 2: close from open, obstruction reverses
      activate = 2'b01;
      tick(); chk_out("s2_dn", 2'b00, 2'b01, 2'b00);
      activate = 2'b00; up_max = 2'b00;
      tick(); chk_out("s2_dn2", 2'b00, 2'b01, 2'b00);
      obstruct = 2'b01;
      tick(); chk_out("s2_reverse", 2'b01, 2'b00, 2'b00);
      obstruct = 2'b00;
      tick(); chk_out("s2_up", 2'b01, 2'b00, 2'b00);
      up_max = 2'b01;
      tick(); chk_out("s2_open", 2'b00, 2'b00, 2'b00);

      // 5: auto-close after 5 idle-open cycles, held off by obstruction
      ticks_chk(4, "s5_wait", 2'b00, 2'b00, 2'b00);
      tick(); chk_out("s5_close", 2'b00, 2'b01, 2'b00);
      up_max = 2'b00; dn_max = 2'b01;
      tick(); chk_out("s5_closed", 2'b00, 2'b00, 2'b00);
      up_max = 2'b01; dn_max = 2'b00; obstruct = 2'b01;
      ticks_chk(10, "s5_obs_hold", 2'b00, 2'b00, 2'b00);
      obstruct = 2'b00;
      ticks_chk(4, "s5_rewait", 2'b00, 2'b00, 2'b00);
      tick(); chk_out("s5_close2", 2'b00, 2'b01, 2'b00);
      up_max = 2'b00; dn_max = 2'b01;
      tick(); chk_out("s5_closed2", 2'b00, 2'b00, 2'b00);

      // 3: stop mid-travel, resume reverses, held button is a single event
      activate = 2'b01;
      tick(); chk_out("s3_up", 2'b01, 2'b00, 2'b00);
      activate = 2'b00; dn_max = 2'b00;
      tick(); chk_out("s3_run", 2'b01, 2'b00, 2'b00);
      activate = 2'b01;
      tick(); chk_out("s3_stop", 2'b00, 2'b00, 2'b00);
      activate = 2'b00;
      tick(); chk_out("s3_stopped", 2'b00, 2'b00, 2'b00);
      activate = 2'b01;
      tick(); chk_out("s3_resume_dn", 2'b00, 2'b01, 2'b00);
      ticks_chk(5, "s3_hold_run", 2'b00, 2'b01, 2'b00);
      dn_max = 2'b01;
      tick(); chk_out("s3_closed", 2'b00, 2'b00, 2'b00);
      ticks_chk(3, "s3_hold_idle", 2'b00, 2'b00, 2'b00);
      activate = 2'b00;
      tick(); chk_out("s3_release", 2'b00, 2'b00, 2'b00);

      // 4: watchdog on door1
      dn_max = 2'b11; activate = 2'b10;
      tick(); chk_out("s4_up", 2'b10, 2'b00, 2'b00);
      dn_max = 2'b01; activate = 2'b00;
      ticks_chk(7, "s4_run", 2'b10, 2'b00, 2'b00);
      tick(); chk_out("s4_timeout", 2'b00, 2'b00, 2'b10);
      activate = 2'b10;
      tick(); chk_out("s4_act_ign", 2'b00, 2'b00, 2'b10);
      activate = 2'b00;
      tick(); chk_out("s4_flt_hold", 2'b00, 2'b00, 2'b10);
      clr_fault = 2'b10;
      tick(); chk_out("s4_clr", 2'b00, 2'b00, 2'b00);
      clr_fault = 2'b00;
      tick(); chk_out("s4_idle", 2'b00, 2'b00, 2'b00);

      // 6: independence and dual-limit fault, table-driven
      for (int i = 0; i < 12; i++) begin
         activate = tbl[i].act; up_max = tbl[i].up; dn_max = tbl[i].dn;
         obstruct = tbl[i].obs; clr_fault = tbl[i].clr;
         tick();
         chk({tbl[i].nm, ".up_m"},  up_m,  tbl[i].e_up);
         chk({tbl[i].nm, ".dn_m"},  dn_m,  tbl[i].e_dn);
         chk({tbl[i].nm, ".fault"}, fault, tbl[i].e_flt);
         chk({tbl[i].nm, ".busy"},  {1'b0, busy}, {1'b0, tbl[i].e_busy});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/garage_ctrl_multi.md
Name: garage_ctrl_multi

Overview:
Parametrised multi-door garage controller. It runs N_DOORS independent per-door state machines, each driving up and down motor enables from an activate button and up/down limit switches. Compared with the single-door controller, it adds mid-travel stop/resume, obstruction auto-reverse, a motor-run watchdog with latched fault, and an optional auto-close timer. It sits between the debounced front-panel and sensor inputs and the motor driver stage.

Parameters:
N_DOORS, 2, number of independent door channels (1..8)
MOVE_TIMEOUT, 1000, max consecutive cycles a motor may run before fault (>=2)
AUTO_CLOSE, 0, cycles a fully open idle door waits before closing; 0 = disabled
CNT_W, 16, per-channel timer width; must hold max(MOVE_TIMEOUT, AUTO_CLOSE)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
activate  in  N_DOORS  per-door button level, synchronous to clk, debounced upstream
up_max  in  N_DOORS  door fully open limit switch
dn_max  in  N_DOORS  door fully closed limit switch
obstruct  in  N_DOORS  beam-break sensor, 1 = obstruction
clr_fault  in  N_DOORS  one-cycle pulse, clears latched fault
up_m  out  N_DOORS  raise motor enable, registered
dn_m  out  N_DOORS  lower motor enable, registered
fault  out  N_DOORS  latched watchdog/sensor fault, registered
busy  out  1  OR of all up_m|dn_m, registered

Behaviour:
- Reset (async, rst=1): every channel goes to IDLE. up_m=dn_m=fault=0, busy=0, timers=0, act_q=0, last_dir=DOWN. Reset mid-travel drops the motors immediately, without waiting for a clock edge.
- Edge detect per channel: act_rise = activate & ~act_q. act_q registers activate. A held button produces exactly one event.
- States: IDLE, MV_UP, MV_DN, FAULT. up_m=(state==MV_UP). dn_m=(state==MV_DN). fault=(state==FAULT). Outputs change on the same edge that samples the causing input, so latency is 1 edge.
- IDLE transitions:
  - If act_rise and up_max=1 and dn_max=1: FAULT (both limit switches active).
  - If act_rise and dn_max=1: MV_UP.
  - If act_rise and up_max=1: MV_DN, unless obstruct=1, in which case stay IDLE.
  - If act_rise with neither limit active (stopped mid-travel): move opposite to last_dir. An obstruction blocks a down move, exactly as above.
  - Auto-close (AUTO_CLOSE>0): while up_max=1, dn_max=0, obstruct=0 and no act_rise, the timer increments. It clears whenever any of those conditions fails. When the timer equals AUTO_CLOSE-1, go to MV_DN.
- MV_UP priority, highest first:
  1. up_max=1: IDLE.
  2. act_rise: IDLE (stop mid-travel).
  3. Timer == MOVE_TIMEOUT-1: FAULT.
  4. Otherwise increment the timer.
- MV_DN priority, highest first:
  1. dn_max=1: IDLE.
  2. obstruct=1: MV_UP (auto-reverse; timer restarts).
  3. act_rise: IDLE.
  4. Timer == MOVE_TIMEOUT-1: FAULT.
  5. Otherwise increment the timer.
- Timer is cleared on every state change. A motor is therefore high for at most MOVE_TIMEOUT cycles per run.
- last_dir is updated on entry to MV_UP (UP) or MV_DN (DOWN).
- FAULT: motors off. Stays in FAULT until clr_fault=1, then goes to IDLE. activate is ignored in FAULT. clr_fault in any other state has no effect.
- The invariant up_m & dn_m == 0 holds for every channel in every cycle.
- Channels are fully independent. Simultaneous events on different doors are all serviced in the same cycle.
- busy is registered from the next-state motor enables. It is therefore cycle-aligned with up_m/dn_m.

Test Plan:
Use N_DOORS=2, MOVE_TIMEOUT=8, AUTO_CLOSE=5 for all scenarios.
1. Reset with rst=1 while door0 is in MV_UP: up_m=0, dn_m=0, fault=0, busy=0 immediately. After release, door0 dn_max=1 and activate pulsed: up_m[0]=1 at the next edge. Raising up_max[0] after 3 cycles gives up_m[0]=0 at the next edge, with fault[0]=0.
2. Door0 open (up_max=1): activate gives dn_m[0]=1. obstruct[0]=1 on cycle 2 gives dn_m[0]=0 and up_m[0]=1 on the next edge. up_max[0]=1 then brings door0 to IDLE.
3. Mid-travel: door0 MV_UP, activate again gives both motors 0. Clear both limits and press activate: dn_m[0]=1 (reverse of last_dir). Holding activate high for 10 cycles produces exactly one transition.
4. Watchdog: door1 dn_max=1 and activate, with limits held at 0. up_m[1] stays high for exactly 8 cycles, then up_m[1]=0 and fault[1]=1. activate is ignored. A clr_fault[1] pulse gives fault[1]=0.
5. Auto-close: door0 up_max=1, idle. dn_m[0] rises 5 cycles later. With obstruct[0]=1 held, dn_m[0] stays 0 indefinitely. Releasing obstruct restarts the 5-cycle count.
6. Independence and fault: door0 and door1 are activated in the same cycle from closed and open respectively, giving up_m=2'b01, dn_m=2'b10, busy=1. Separately, up_max=dn_max=1 plus activate gives fault=1 with no motor pulse.
